reg_bank_arbiter: RTL and testbench



---
 rtl/reg_bank_arbiter_if.sv | 43 ++++
 rtl/reg_bank_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_arbiter_if.sv
// Request/response bundle between client requesters and reg_bank_arbiter.
// The req_lock signal exists only when REGARB_LOCK_EN is defined.
interface reg_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
);
    localparam int AW  = $clog2(DEPTH);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_rdata;
`ifdef REGARB_LOCK_EN
    logic [NREQ-1:0]       req_lock;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_lock, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_lock, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rdata
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rdata
    );
`endif
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbitrated single-beat access to a small register bank.
// Define REGARB_LOCK_EN to let the current owner keep the grant via req_lock.
module reg_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 7
) (
    input  logic              clock,
    input  logic              rst_n,
    reg_bank_arbiter_if.slave bus,
    output logic [WIDTH-1:0]  get_reg_ret
);
    localparam int AW  = $clog2(DEPTH);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   own_id_q, own_id_d;
    logic             own_write_q, own_write_d;
    logic [AW-1:0]    own_addr_q, own_addr_d;
    logic [WIDTH-1:0] own_wdata_q, own_wdata_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];
`ifdef REGARB_LOCK_EN
    logic             lock_q, lock_d;
`endif

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic             win_forced;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                               input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NREQ)) begin
            sum = sum - 32'(NREQ);
        end
        return sum[IDW-1:0];
    endfunction

    // Search from rr_ptr upward; a held lock overrides the rotation.
    always_comb begin
        win_found  = 1'b0;
        win_id     = rr_ptr_q;
        win_forced = 1'b0;
        for (int unsigned k = 0; k < 32'(NREQ); k++) begin
            if (!win_found && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
                win_found = 1'b1;
                win_id    = wrap_add(rr_ptr_q, k);
            end
        end
`ifdef REGARB_LOCK_EN
        if (lock_q && bus.req_valid[own_id_q] && bus.req_lock[own_id_q]) begin
            win_found  = 1'b1;
            win_id     = own_id_q;
            win_forced = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_found) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        own_id_d    = own_id_q;
        own_write_d = own_write_q;
        own_addr_d  = own_addr_q;
        own_wdata_d = own_wdata_q;
        result_d    = result_q;
        rsp_id_d    = rsp_id_q;
        bank_d      = bank_q;
`ifdef REGARB_LOCK_EN
        lock_d      = lock_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    own_id_d    = win_id;
                    own_write_d = bus.req_write[win_id];
                    own_addr_d  = bus.req_addr[int'(win_id)*AW +: AW];
                    own_wdata_d = bus.req_wdata[int'(win_id)*WIDTH +: WIDTH];
                    rr_ptr_d    = win_forced ? rr_ptr_q : wrap_add(win_id, 1);
                end
`ifdef REGARB_LOCK_EN
                lock_d = 1'b0;
`endif
            end
            ACCESS: begin
                if (own_write_q) begin
                    bank_d[own_addr_q] = own_wdata_q;
                    result_d           = own_wdata_q;
                end else begin
                    result_d = bank_q[own_addr_q];
                end
                rsp_id_d = own_id_q;
            end
            RESP: begin
`ifdef REGARB_LOCK_EN
                if (bus.rsp_ready) begin
                    lock_d = bus.req_lock[own_id_q] & bus.req_valid[own_id_q];
                end
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            own_id_q    <= '0;
            own_write_q <= 1'b0;
            own_addr_q  <= '0;
            own_wdata_q <= '0;
            result_q    <= '0;
            rsp_id_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= WIDTH'(RESET_VAL);
            end
`ifdef REGARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            own_id_q    <= own_id_d;
            own_write_q <= own_write_d;
            own_addr_q  <= own_addr_d;
            own_wdata_q <= own_wdata_d;
            result_q    <= result_d;
            rsp_id_q    <= rsp_id_d;
            bank_q      <= bank_d;
`ifdef REGARB_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    // req_ready is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        if (rst_n && (state_q == IDLE) && win_found) begin
            bus.req_ready[win_id] = 1'b1;
        end
        if (state_q == RESP) begin
            bus.rsp_valid = 1'b1;
        end
    end

    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rdata = result_q;
    assign get_reg_ret   = bank_q[0];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_reg_bank_arbiter;
    localparam int NREQ      = 4;
    localparam int DEPTH     = 4;
    localparam int WIDTH     = 8;
    localparam int RESET_VAL = 7;
    localparam int AW        = 2;

    logic             clock = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] get_reg_ret;

    always #5 clock = ~clock;

    reg_bank_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    reg_bank_arbiter #(
        .NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .RESET_VAL(RESET_VAL)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .bus(bus.slave),
        .get_reg_ret(get_reg_ret)
    );

    // Pending request per requester; held until the model grants it.
    bit  pend_v [NREQ];
    bit  pend_w [NREQ];
    bit  pend_l [NREQ];
    int  pend_a [NREQ];
    int  pend_d [NREQ];
    bit  rsp_rdy;

    int  mdl_bank [DEPTH];
    int  mdl_grants [NREQ];
    int  mdl_rr, mdl_phase, mdl_rsp_id, mdl_rsp_data;
    int  cur_id, cur_a, cur_d;
    bit  cur_w, mdl_locked;

    int  check_count = 0;
    int  error_count = 0;
    int  cyc = 0;
    int  grant_log [$];
    int  grant_cyc [$];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed != expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]                = pend_v[i];
            bus.req_write[i]                = pend_w[i];
            bus.req_addr[i*AW +: AW]        = AW'(pend_a[i]);
            bus.req_wdata[i*WIDTH +: WIDTH] = WIDTH'(pend_d[i]);
`ifdef REGARB_LOCK_EN
            bus.req_lock[i]                 = pend_l[i];
`endif
        end
        bus.rsp_ready = rsp_rdy;
    endtask

    task automatic new_req(input int i, input bit w, input int a, input int d);
        pend_v[i] = 1'b1;
        pend_w[i] = w;
        pend_a[i] = a;
        pend_d[i] = d;
    endtask

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic run_cycle();
        int              win;
        bit              forced;
        logic [NREQ-1:0] exp_ready;
        applyStimulus();
        #1;
        win    = -1;
        forced = 1'b0;
        if (mdl_phase == 0) begin
            if (mdl_locked && pend_v[cur_id] && pend_l[cur_id]) begin
                win    = cur_id;
                forced = 1'b1;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (win < 0 && pend_v[(mdl_rr + k) % NREQ]) win = (mdl_rr + k) % NREQ;
                end
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        checkOutput("req_ready", int'(bus.req_ready), int'(exp_ready));
        checkOutput("rsp_valid", int'(bus.rsp_valid), (mdl_phase == 2) ? 1 : 0);
        checkOutput("rsp_id", int'(bus.rsp_id), mdl_rsp_id);
        checkOutput("rsp_rdata", int'(bus.rsp_rdata), mdl_rsp_data);
        checkOutput("get_reg_ret", int'(get_reg_ret), mdl_bank[0]);
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i]) begin
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
            end
        end
        @(posedge clock);
        case (mdl_phase)
            0: begin
                if (win >= 0) begin
                    cur_id = win;
                    cur_w  = pend_w[win];
                    cur_a  = pend_a[win];
                    cur_d  = pend_d[win];
                    pend_v[win] = 1'b0;
                    if (!forced) mdl_rr = (win + 1) % NREQ;
                    mdl_grants[win]++;
                    mdl_phase = 1;
                end
                mdl_locked = 1'b0;
            end
            1: begin
                if (cur_w) begin
                    mdl_bank[cur_a] = cur_d;
                    mdl_rsp_data    = cur_d;
                end else begin
                    mdl_rsp_data = mdl_bank[cur_a];
                end
                mdl_rsp_id = cur_id;
                mdl_phase  = 2;
            end
            default: begin
                if (rsp_rdy) begin
                    mdl_phase = 0;
`ifdef REGARB_LOCK_EN
                    mdl_locked = pend_v[cur_id] && pend_l[cur_id];
`endif
                end
            end
        endcase
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_ready", int'(bus.req_ready), 0);
        checkOutput("rst_rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("rst_rsp_id", int'(bus.rsp_id), 0);
        checkOutput("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
        checkOutput("rst_get_reg_ret", int'(get_reg_ret), RESET_VAL);
        for (int i = 0; i < DEPTH; i++) mdl_bank[i] = RESET_VAL;
        for (int i = 0; i < NREQ; i++) begin
            pend_v[i] = 1'b0;
            pend_l[i] = 1'b0;
            mdl_grants[i] = 0;
        end
        mdl_rr = 0; mdl_phase = 0; mdl_rsp_id = 0; mdl_rsp_data = 0; mdl_locked = 1'b0;
        rsp_rdy = 1'b1;
        applyStimulus();
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        rst_n   = 1'b1;
        rsp_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pend_v[i] = 1'b0; pend_w[i] = 1'b0; pend_l[i] = 1'b0; pend_a[i] = 0; pend_d[i] = 0;
        end
        applyStimulus();
        @(negedge clock);
        do_reset();

        $display("[TB] read after reset, then write/read through another requester");
        new_req(0, 1'b0, 0, 0);
        repeat (4) run_cycle();
        new_req(2, 1'b1, 3, 'hA5);
        repeat (4) run_cycle();
        new_req(1, 1'b0, 3, 0);
        repeat (4) run_cycle();

        $display("[TB] all requesters valid, round-robin order");
        do_reset();
        grant_log.delete();
        grant_cyc.delete();
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i]) new_req(i, 1'b0, $urandom_range(0, DEPTH-1), 0);
            end
            run_cycle();
        end
        checkOutput("rr_grant_count", (grant_log.size() >= 5) ? 1 : 0, 1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            checkOutput("rr_order", grant_log[k], exp_order[k]);
            if (k > 0) checkOutput("rr_spacing", grant_cyc[k] - grant_cyc[k-1], 3);
        end

        $display("[TB] response backpressure");
        rsp_rdy = 1'b0;
        for (int n = 0; n < 6 && mdl_phase != 2; n++) run_cycle();
        repeat (5) run_cycle();
        rsp_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        for (int n = 0; n < 6 && mdl_phase != 0; n++) run_cycle();

        $display("[TB] reset during response of a write to register 0");
        new_req(0, 1'b1, 0, 'h3C);
        rsp_rdy = 1'b0;
        for (int n = 0; n < 6 && mdl_phase != 2; n++) run_cycle();
        run_cycle();
        new_req(1, 1'b0, 2, 0);
        applyStimulus();
        #2;
        do_reset();
        new_req(0, 1'b0, 0, 0);
        repeat (4) run_cycle();

`ifdef REGARB_LOCK_EN
        $display("[TB] lock held by requester 1 across three writes");
        do_reset();
        grant_log.delete();
        grant_cyc.delete();
        for (int n = 0; n < 14; n++) begin
            if (!pend_v[1] && mdl_grants[1] < 3) begin
                new_req(1, 1'b1, n % DEPTH, n + 16);
                pend_l[1] = 1'b1;
            end
            if (n == 1) new_req(0, 1'b0, 1, 0);
            run_cycle();
        end
        pend_l[1] = 1'b0;
        checkOutput("lock_grant_count", (grant_log.size() >= 4) ? 1 : 0, 1);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
            checkOutput("lock_order", grant_log[k], (k < 3) ? 1 : 0);
        end
        for (int n = 0; n < 6; n++) run_cycle();
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
                    new_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1),
                            $urandom_range(0, 255));
                end
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
            run_cycle();
        end
        rsp_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        repeat (4) run_cycle();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end
endmodule
